// File: rtl/i2c_slave_wr.sv
// -----------------------------------------------------------------------------
// i2c_slave_wr
// I2C target (slave) write receiver. It watches the shared scl/sda bus for
// START/STOP conditions and matches its own 7-bit address on write requests.
// It ACKs the address byte, one register-pointer byte and any number of data
// bytes. Each data byte is presented on a one-cycle write strobe together with
// an auto-incrementing register address.
//
// Ports:
//   clk      in    system clock, at least 8x the SCL frequency
//   rst      in    asynchronous active-low reset
//   scl      in    bus clock from the master (never stretched here)
//   sda      inout open-drain data: 1'b0 while acking, otherwise 1'bz
//   wr_en    out   one-cycle strobe: a data byte was received and acked
//   wr_addr  out   register address belonging to the current wr_en
//   wr_data  out   data byte belonging to the current wr_en
//   busy     out   high while a transaction addressed to this slave runs
//   addr_hit out   high from the address ACK until the next STOP or START
// -----------------------------------------------------------------------------
module i2c_slave_wr #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h66,
  parameter int         SYNC_STAGES = 2      // minimum 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       addr_hit
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_REG_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  // Synchronizers and edge detectors. Flops reset to 1 to match an idle,
  // pulled-up bus.
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  // Bus events are ignored until the synchronizer and edge flops hold real
  // pad values. Otherwise releasing reset while sda is low and scl is high
  // would look like a START.
  logic [SYNC_STAGES:0]   r_warm;

  logic w_scl;
  logic w_sda;
  logic w_live;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_warm     <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_warm     <= {r_warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_live     = r_warm[SYNC_STAGES];
  assign w_scl_rise = w_live &  w_scl & ~r_scl_d;
  assign w_scl_fall = w_live & ~w_scl &  r_scl_d;
  // START/STOP require scl to have been high on both samples, so an sda
  // change that coincides with an scl edge is treated as data.
  assign w_start    = w_live & w_scl & r_scl_d &  r_sda_d & ~w_sda;
  assign w_stop     = w_live & w_scl & r_scl_d & ~r_sda_d &  w_sda;

  // Byte assembly
  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_sda_oe;
  logic       w_sda_oe_nxt;
  logic [6:0] r_shift;
  logic [2:0] r_bitcnt;
  logic [7:0] r_ptr;
  logic       r_wr_en;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic       r_busy;
  logic       r_addr_hit;

  logic       w_shift_state;
  logic       w_bit_edge;
  logic       w_byte_done;
  logic [7:0] w_byte;
  logic       w_addr_match;

  assign w_shift_state = (r_state == S_ADDR) || (r_state == S_REG) ||
                         (r_state == S_DATA);
  assign w_bit_edge    = w_scl_rise & w_shift_state & ~w_start & ~w_stop;
  assign w_byte_done   = w_bit_edge & (r_bitcnt == 3'd7);
  assign w_byte        = {r_shift, w_sda};
  assign w_addr_match  = (w_byte[7:1] == SLAVE_ADDR) & ~w_byte[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_sda_oe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sda_oe <= w_sda_oe_nxt;
    end
  end

  // ACK states: the first scl fall (end of the 8th clock) starts driving
  // sda low, the second scl fall (end of the 9th clock) releases it. sda
  // therefore changes only while scl is low.
  always_comb begin
    w_state_nxt  = r_state;
    w_sda_oe_nxt = r_sda_oe;
    if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_sda_oe_nxt = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_byte_done) w_state_nxt = w_addr_match ? S_ADDR_ACK : S_IGNORE;
        end
        S_REG: begin
          if (w_byte_done) w_state_nxt = S_REG_ACK;
        end
        S_DATA: begin
          if (w_byte_done) w_state_nxt = S_DATA_ACK;
        end
        S_ADDR_ACK, S_REG_ACK, S_DATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = (r_state == S_ADDR_ACK) ? S_REG : S_DATA;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shift register, pointer and write strobe. The 3-bit counter wraps from
  // 7 to 0 on the last bit, so each byte starts from a clean count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_ptr      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_addr_hit <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      // Pointer advances the cycle after the strobe, wrapping FF -> 00.
      if (r_wr_en) r_ptr <= r_ptr + 8'd1;

      if (w_start || w_stop) begin
        // Partial byte is dropped.
        r_shift  <= '0;
        r_bitcnt <= '0;
      end else if (w_bit_edge) begin
        r_shift  <= w_byte[6:0];
        r_bitcnt <= r_bitcnt + 3'd1;
        if (w_byte_done && (r_state == S_REG)) r_ptr <= w_byte;
        if (w_byte_done && (r_state == S_DATA)) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= w_byte;
          r_wr_addr <= r_ptr;
        end
      end

      if (w_stop) begin
        r_busy <= 1'b0;
      end else if (w_byte_done && (r_state == S_ADDR) && w_addr_match) begin
        r_busy <= 1'b1;
      end

      if (w_start || w_stop) begin
        r_addr_hit <= 1'b0;
      end else if (w_byte_done && (r_state == S_ADDR) && w_addr_match) begin
        r_addr_hit <= 1'b1;
      end
    end
  end

  assign sda      = r_sda_oe ? 1'b0 : 1'bz;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;
  assign addr_hit = r_addr_hit;

endmodule

// File: doc/i2c_slave_wr.md
Name: i2c_slave_wr

Overview:
- I2C target (slave) receiver: the far end of the team's tri-state I2C write master.
- Detects START/STOP and matches its 7-bit address. ACKs the address byte, a register-pointer byte and any number of data bytes by pulling the open-drain sda low.
- Presents each received data byte on a one-cycle write strobe with an auto-incrementing register address.
- Sits on the shared scl/sda bus beside the master; the write strobe drives a local register file or CSR block.

Parameters:
- SLAVE_ADDR, 7'h66, own 7-bit bus address (address byte 8'hCC = write, 8'hCD = read).
- SYNC_STAGES, 2, synchronizer flops on scl and sda inputs (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- rst  input  1  asynchronous active-low reset.
- scl  input  1  bus clock from the master; this block never stretches it.
- sda  inout  1  open-drain data: driven 1'b0 when acking, otherwise 1'bz; external pull-up assumed.
- wr_en  output  1  one-cycle strobe: a data byte was received and acked.
- wr_addr  output  8  register address for the current wr_en.
- wr_data  output  8  data byte for the current wr_en.
- busy  output  1  high while a transaction addressed to this slave is in progress.
- addr_hit  output  1  high from address-ACK until the next STOP or START.

Behaviour:
- Reset (rst=0, async):
  - sda released (hi-Z); state IDLE.
  - wr_en=0, wr_addr=8'h00, wr_data=8'h00, busy=0, addr_hit=0.
  - Internal shift register, bit counter and pointer cleared.
- Input conditioning:
  - scl and sda each pass through SYNC_STAGES flops, then a one-flop edge detector.
  - Bus events are therefore seen SYNC_STAGES+1 clk after the pad change.
- Bus events:
  - START: sda falls while scl high. Recognised in ANY state (covers repeated start). Action: go to ADDR, bit count 0, addr_hit=0.
  - STOP: sda rises while scl high. Recognised in any state. Action: go to IDLE, release sda, busy=0, addr_hit=0.
  - START/STOP take priority over a coincident data edge.
- Data sampling: sda sampled on the synchronized scl rising edge, MSB first.
- States:
  - IDLE: sda released; waits for START.
  - ADDR: shifts 8 bits; decides on the 8th rising edge.
    - byte[7:1]==SLAVE_ADDR and byte[0]==0 → ADDR_ACK, busy=1.
    - Any other byte, including a read request to own address → IGNORE, no ACK.
  - ADDR_ACK: sda driven low from the next scl falling edge until the following scl falling edge (the 9th clock); addr_hit=1; then REG.
  - REG: shifts 8 bits; loads the pointer on the 8th rising edge; then REG_ACK.
  - REG_ACK: ACK timing as ADDR_ACK; then DATA.
  - DATA: shifts 8 bits.
    - On the 8th rising edge: next clk wr_en=1 for exactly one cycle, wr_data=byte, wr_addr=pointer.
    - Pointer increments the cycle after wr_en, wrapping 8'hFF→8'h00.
    - Then DATA_ACK.
  - DATA_ACK: ACK timing as ADDR_ACK; returns to DATA for the next byte.
  - IGNORE: sda never driven; leaves only on START or STOP.
- Hold timing: sda must change only after scl is low (falling-edge driven), so the master sees stable data during scl high.
- wr_addr/wr_data hold their last values between strobes.
- A STOP or START arriving mid-byte discards the partial byte: no wr_en, and sda is released immediately.
- The block never NACKs actively; NACK means leaving sda released.

Test Plan:
1. START, 8'hCC, 8'h81, 8'hB7, STOP → sda low on all three 9th clocks; single wr_en with wr_addr=8'h81, wr_data=8'hB7; busy falls at STOP.
2. START, 8'hCC, 8'hFE, 8'h6A, 8'h11, 8'h22, STOP → three wr_en pulses: (FE,6A), (FF,11), (00,22); verifies pointer wrap.
3. START, 8'h9C (address 7'h4E), 8'h81, 8'hB7, STOP → sda never driven low, no wr_en, busy and addr_hit stay 0.
4. START, 8'hCD (read to own address) → NACK (sda high on 9th clock); state IGNORE; no wr_en until the next START.
5. START, 8'hCC, 8'h10, 8'hAA, repeated START, 8'hCC, 8'h20, 8'hBB, STOP → writes (10,AA) then (20,BB); addr_hit drops at the Sr and re-asserts at the second address ACK.
6. Assert rst=0 during bit 4 of a data byte, including while sda is being driven during an ACK → sda hi-Z immediately and all outputs zero. Release rst mid-byte → ignores traffic until the next START; then a full transfer per scenario 1 completes correctly.
